debug_step_ctrl: RTL and testbench
==================================

Name: debug_step_ctrl

Overview:
Single-cycle CPU debug sequencer. Consumes one-cycle key pulses from the board debouncers and generates the CPU clock-enable `cpu_ce`, so the core can be single-stepped, free-run at a slow visible rate, or burst-stepped a fixed count. It sits between the debounced keys and the CPU top-level. It also reports mode and a step counter to the seven-segment and LED debug logic.

Parameters:
- RUN_DIV, 3_000_000, clk cycles between `cpu_ce` pulses in RUN mode (4 Hz at 12 MHz); must be >= 2.
- BURST_LEN, 16, `cpu_ce` pulses issued per burst; must be >= 1.
- PC_W, 32, program-counter width.
- CNT_W, 16, width of `step_cnt`.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_step  in  1  one-cycle pulse: single step.
- key_run  in  1  one-cycle pulse: run/pause toggle.
- key_burst  in  1  one-cycle pulse: start burst.
- cpu_halted  in  1  level, CPU has executed halt.
- pc  in  PC_W  current CPU PC (used only with the optional feature).
- cpu_ce  out  1  CPU clock enable; one CPU instruction per high cycle.
- mode  out  2  current state encoding.
- busy  out  1  high when mode != IDLE.
- step_cnt  out  CNT_W  total `cpu_ce` pulses since reset.

Behaviour:
- Reset (rst=0, async): state IDLE. `cpu_ce`=0, `mode`=2'b00, `busy`=0, `step_cnt`=0, divider=0, burst counter=0.
- State encoding: IDLE=00, STEP=01, RUN=10, BURST=11. `mode` is the state register itself.
- `cpu_ce` = (state==STEP) | (state==BURST) | (state==RUN & divider at terminal count & !cpu_halted). All terms are decoded from registers; there is no combinational path from the keys to `cpu_ce`.
- IDLE:
  - If `cpu_halted`=1, all keys are ignored.
  - Otherwise, for simultaneous pulses the priority is key_run > key_burst > key_step.
  - key_run -> RUN, divider cleared.
  - key_burst -> BURST, burst counter loaded with BURST_LEN.
  - key_step -> STEP.
- STEP: lasts exactly 1 cycle with `cpu_ce`=1, then IDLE. All keys are ignored. A key_step sampled at edge k gives `cpu_ce` high from edge k to edge k+1.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps. `cpu_ce`=1 for the one cycle where divider==RUN_DIV-1.
  - The first pulse comes RUN_DIV cycles after entry.
  - key_run -> IDLE with divider cleared; if this coincides with terminal count, that pulse is still issued.
  - `cpu_halted`=1 -> IDLE next edge, and `cpu_ce` is suppressed in that cycle.
  - key_step and key_burst are ignored.
- BURST:
  - `cpu_ce`=1 every cycle while in BURST; the burst counter decrements each cycle.
  - When the counter==1, next state is IDLE, giving exactly BURST_LEN pulses.
  - key_run aborts to IDLE next edge; the current cycle's pulse is still issued.
  - `cpu_halted`=1 -> IDLE next edge with the current pulse suppressed.
  - key_step and key_burst are ignored.
- `step_cnt` increments on every cycle with `cpu_ce`=1 and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation aborts any mode immediately; no residual `cpu_ce`.

Optional Feature:
- Macro: DEBUG_STEP_BREAKPOINT_EN.
- When defined:
  - Adds ports `bp_addr` (in, PC_W), `bp_valid` (in, 1) and `bp_hit` (out, 1, reset 0).
  - In RUN or BURST, if `bp_valid` and `pc`==`bp_addr`, the block suppresses `cpu_ce` that cycle, goes to IDLE next edge and sets `bp_hit`.
  - `bp_hit` is sticky; it is cleared on the next accepted key_run, key_burst or key_step.
  - STEP ignores the breakpoint, so the user can step off it.
- When undefined: these ports and all compare logic are absent, and RUN/BURST are unaffected by `pc`.

Decomposition:
- Package `debug_ctrl_pkg` holds:
  - state encoding constants IDLE, STEP, RUN and BURST;
  - the 2-bit mode type;
  - the default RUN_DIV and BURST_LEN values.
- One sub-module, `rate_divider`: a parameterised modulo-RUN_DIV counter with sync clear and enable, producing a `tick` at terminal count.
- The FSM, burst counter and step counter stay in the top module.

Test Plan:
- Use RUN_DIV=4 and BURST_LEN=3 for all scenarios.
- Reset then key_step at edge 10 -> `cpu_ce` high only in cycle 10-11, `step_cnt`=1, `mode` returns to 00.
- key_burst -> `cpu_ce` high exactly 3 consecutive cycles, then `mode`=00, `step_cnt`=3. key_step during the burst has no effect.
- key_run -> `cpu_ce` pulses every 4 cycles, first 4 cycles after entry. A second key_run on a terminal-count cycle -> that pulse is issued, then IDLE.
- RUN with `cpu_halted` raised -> no further `cpu_ce`, IDLE next edge; later key_step/key_run are ignored while `cpu_halted`=1.
- Simultaneous key_run, key_burst and key_step in IDLE -> `mode`=10. Drive rst low mid-BURST -> `cpu_ce`=0 and `step_cnt`=0 immediately.
- With DEBUG_STEP_BREAKPOINT_EN, `bp_addr`=0x0C, `pc` advancing by 4 per `cpu_ce` from 0, in RUN -> stops with `pc`=0x0C and `bp_hit`=1; a following key_step -> one `cpu_ce` and `bp_hit`=0.

Source files
------------

// File: rtl/debug_ctrl_pkg.sv
// Shared definitions for the CPU debug step sequencer: mode encoding and
// default timing parameters.
package debug_ctrl_pkg;

  // The mode value is the FSM state register itself, so the encoding is fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEP  = 2'b01,
    RUN   = 2'b10,
    BURST = 2'b11
  } mode_t;

  localparam int unsigned RUN_DIV_DEFAULT   = 3_000_000;
  localparam int unsigned BURST_LEN_DEFAULT = 16;

endpackage

// File: rtl/rate_divider.sv
// Modulo-DIV counter with synchronous clear and count enable; tick is decoded
// from the counter register at terminal count (DIV-1).
module rate_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/debug_step_ctrl.sv
// CPU debug sequencer: turns debounced key pulses into single-step, slow-run
// and fixed-length burst clock enables. Optional breakpoint: DEBUG_STEP_BREAKPOINT_EN.
module debug_step_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int unsigned RUN_DIV   = RUN_DIV_DEFAULT,
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_step,
  input  logic             key_run,
  input  logic             key_burst,
  input  logic             cpu_halted,
  input  logic [PC_W-1:0]  pc,
`ifdef DEBUG_STEP_BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit,
`endif
  output logic             cpu_ce,
  output logic [1:0]       mode,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  mode_t         state;
  logic [BW-1:0] burst_left;
  logic          run_tick;
  logic          bp_stop;
  logic          div_clr;
  logic          key_any;

  assign key_any = key_run | key_burst | key_step;

`ifdef DEBUG_STEP_BREAKPOINT_EN
  // STEP is deliberately excluded so the user can step off a breakpoint.
  assign bp_stop = bp_valid && (pc == bp_addr) && ((state == RUN) || (state == BURST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_hit <= 1'b0;
    end else if (bp_stop) begin
      bp_hit <= 1'b1;
    end else if ((state == IDLE) && !cpu_halted && key_any) begin
      bp_hit <= 1'b0;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_stop   = 1'b0;
`endif

  // Divider held at zero outside RUN and on every RUN exit, so each entry
  // waits a full RUN_DIV cycles before the first pulse.
  assign div_clr = (state != RUN) | key_run | cpu_halted | bp_stop;

  rate_divider #(
    .DIV (RUN_DIV)
  ) u_rate_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (state == RUN),
    .tick (run_tick)
  );

  // Decoded from registers; cpu_halted and the breakpoint only ever suppress.
  assign cpu_ce = (state == STEP)
                | (!cpu_halted && !bp_stop &&
                   ((state == BURST) || ((state == RUN) && run_tick)));

  assign mode = state;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      burst_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cpu_halted) begin
            if (key_run) begin
              state <= RUN;
            end else if (key_burst) begin
              state      <= BURST;
              burst_left <= BW'(BURST_LEN);
            end else if (key_step) begin
              state <= STEP;
            end
          end
        end
        STEP: state <= IDLE;
        RUN: begin
          if (key_run || cpu_halted || bp_stop) begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (key_run || cpu_halted || bp_stop || (burst_left == BW'(1))) begin
            state      <= IDLE;
            burst_left <= '0;
          end else begin
            burst_left <= burst_left - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
    end else if (cpu_ce) begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: directed scenarios plus random key
// traffic against a behavioural model of the sequencing rules.
module tb_debug_step_ctrl;

  localparam int RUN_DIV   = 4;
  localparam int BURST_LEN = 3;
  localparam int PC_W      = 32;
  localparam int CNT_W     = 4;  // narrow so the random run wraps step_cnt

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             key_step = 1'b0;
  logic             key_run = 1'b0;
  logic             key_burst = 1'b0;
  logic             cpu_halted = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             cpu_ce;
  logic [1:0]       mode;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;
`ifdef DEBUG_STEP_BREAKPOINT_EN
  logic [PC_W-1:0]  bp_addr = '0;
  logic             bp_valid = 1'b0;
  logic             bp_hit;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  debug_step_ctrl #(
    .RUN_DIV   (RUN_DIV),
    .BURST_LEN (BURST_LEN),
    .PC_W      (PC_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_step   (key_step),
    .key_run    (key_run),
    .key_burst  (key_burst),
    .cpu_halted (cpu_halted),
    .pc         (pc),
`ifdef DEBUG_STEP_BREAKPOINT_EN
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .bp_hit     (bp_hit),
`endif
    .cpu_ce     (cpu_ce),
    .mode       (mode),
    .busy       (busy),
    .step_cnt   (step_cnt)
  );

  logic [CNT_W+3:0] dut_vec;
  assign dut_vec = {cpu_ce, mode, busy, step_cnt};

  // Reference model: mode number, cycles spent in RUN, pulses left in a burst.
  int               m_mode = 0;
  int               m_run_cycles = 0;
  int               m_left = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_bp_hit = 1'b0;
  bit               pc_follow = 1'b0;

  function automatic logic m_bp_match();
`ifdef DEBUG_STEP_BREAKPOINT_EN
    return (m_mode >= 2) && bp_valid && (pc == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_ce();
    case (m_mode)
      1:       return 1'b1;
      2:       return !cpu_halted && !m_bp_match() && ((m_run_cycles % RUN_DIV) == RUN_DIV - 1);
      3:       return !cpu_halted && !m_bp_match();
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W+3:0] m_vec();
    return {m_ce(), 2'(m_mode), (m_mode != 0), m_cnt};
  endfunction

  // Apply the rules for the clock edge that has just passed.
  task automatic m_advance();
    logic ce, bpm;
    ce  = m_ce();
    bpm = m_bp_match();
    if (ce) begin
      m_cnt = m_cnt + 1'b1;
      if (pc_follow) pc = pc + 32'd4;
    end
    if (bpm) m_bp_hit = 1'b1;
    case (m_mode)
      0: if (!cpu_halted) begin
           if (key_run || key_burst || key_step) m_bp_hit = 1'b0;
           if (key_run) begin m_mode = 2; m_run_cycles = 0; end
           else if (key_burst) begin m_mode = 3; m_left = BURST_LEN; end
           else if (key_step) m_mode = 1;
         end
      1: m_mode = 0;
      2: if (cpu_halted || key_run || bpm) m_mode = 0; else m_run_cycles++;
      default: if (cpu_halted || key_run || bpm || m_left == 1) m_mode = 0; else m_left--;
    endcase
  endtask

  task automatic m_reset();
    m_mode = 0; m_run_cycles = 0; m_left = 0; m_cnt = '0; m_bp_hit = 1'b0;
  endtask

  // One cycle: advance the model at the falling edge, then drive new inputs.
  task automatic drive(input logic s, input logic r, input logic b, input logic h);
    @(negedge clk);
    m_advance();
    key_step = s; key_run = r; key_burst = b; cpu_halted = h;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    key_step = 0; key_run = 0; key_burst = 0; cpu_halted = 0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    if (cpu_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce: got %b want 0", cpu_ce); end
    vectors++;
    if (mode !== 2'b00) begin miscompares++; $display("FAIL reset_mode: got %b want 00", mode); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (step_cnt !== '0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", step_cnt); end
    vectors++;
  endtask

  task automatic test_step();
    logic [CNT_W-1:0] c0, d;
    int ce_seen = 0, ce_at = -1;
    c0 = step_cnt;
    for (int i = 0; i < 14; i++) begin
      drive(i == 9, 1'b0, 1'b0, 1'b0);
      if (dut_vec !== m_vec()) begin miscompares++; $display("FAIL step cyc%0d: dut=%h model=%h", i, dut_vec, m_vec()); end
      vectors++;
      if (cpu_ce) begin ce_seen++; ce_at = i; end
    end
    d = step_cnt - c0;
    if (ce_seen != 1 || ce_at != 10 || d != 1 || mode !== 2'b00) begin
      miscompares++;
      $display("FAIL step_total: pulses=%0d at=%0d dcnt=%0d mode=%b want 1 at 10 dcnt 1 mode 00", ce_seen, ce_at, d, mode);
    end
    vectors++;
  endtask

  task automatic test_burst();
    logic [CNT_W-1:0] c0, d;
    int ce_seen = 0, first = -1, last = -1;
    c0 = step_cnt;
    for (int i = 0; i < 9; i++) begin
      drive(i == 2, 1'b0, i == 0, 1'b0);
      if (dut_vec !== m_vec()) begin miscompares++; $display("FAIL burst cyc%0d: dut=%h model=%h", i, dut_vec, m_vec()); end
      vectors++;
      if (cpu_ce) begin ce_seen++; if (first < 0) first = i; last = i; end
    end
    d = step_cnt - c0;
    if (ce_seen != 3 || first != 1 || last != 3 || d != 3 || mode !== 2'b00) begin
      miscompares++;
      $display("FAIL burst_total: pulses=%0d first=%0d last=%0d dcnt=%0d mode=%b want 3,1,3,3,00", ce_seen, first, last, d, mode);
    end
    vectors++;
  endtask

  task automatic test_run();
    logic want;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    // RUN begins at i=0; pulses at i=3,7,11,15; second key_run on the i=15 pulse.
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, i == 15, 1'b0, 1'b0);
      want = (i <= 15) && ((i % RUN_DIV) == RUN_DIV - 1);
      if (dut_vec !== m_vec()) begin miscompares++; $display("FAIL run cyc%0d: dut=%h model=%h", i, dut_vec, m_vec()); end
      vectors++;
      if (cpu_ce !== want || mode !== ((i <= 15) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL run_pattern cyc%0d: ce=%b mode=%b want ce=%b", i, cpu_ce, mode, want);
      end
      vectors++;
    end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    // Halt rises on the first terminal-count cycle; then keys with halt held.
    for (int i = 0; i < 10; i++) begin
      drive(i == 5, i == 7, 1'b0, i >= 3);
      if (dut_vec !== m_vec()) begin miscompares++; $display("FAIL halt cyc%0d: dut=%h model=%h", i, dut_vec, m_vec()); end
      vectors++;
      if (cpu_ce !== 1'b0 || mode !== ((i <= 3) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL halt_pattern cyc%0d: ce=%b mode=%b", i, cpu_ce, mode);
      end
      vectors++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (mode !== 2'b10 || dut_vec !== m_vec()) begin
      miscompares++;
      $display("FAIL priority: mode=%b dut=%h model=%h want mode 10", mode, dut_vec, m_vec());
    end
    vectors++;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (mode !== 2'b00) begin miscompares++; $display("FAIL priority_exit: mode=%b want 00", mode); end
    vectors++;
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (cpu_ce !== 1'b1 || dut_vec !== m_vec()) begin
      miscompares++;
      $display("FAIL midburst_pre: dut=%h model=%h", dut_vec, m_vec());
    end
    vectors++;
    #2;
    rst = 1'b0;
    #1;
    if (cpu_ce !== 1'b0 || step_cnt !== '0 || mode !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midburst_reset: ce=%b cnt=%0d mode=%b busy=%b want 0,0,00,0", cpu_ce, step_cnt, mode, busy);
    end
    vectors++;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic h = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) h = ~h;
      pc = $urandom;
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, h);
      if (dut_vec !== m_vec()) begin miscompares++; $display("FAIL random cyc%0d: dut=%h model=%h", i, dut_vec, m_vec()); end
      vectors++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef DEBUG_STEP_BREAKPOINT_EN
  task automatic test_breakpoint();
    bit stopped = 1'b0;
    int ce_seen = 0;
    apply_reset();
    pc = '0; bp_addr = 32'h0000_000C; bp_valid = 1'b1; pc_follow = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (dut_vec !== m_vec() || bp_hit !== m_bp_hit) begin
        miscompares++;
        $display("FAIL bp_run cyc%0d: dut=%h model=%h hit=%b/%b", i, dut_vec, m_vec(), bp_hit, m_bp_hit);
      end
      vectors++;
      if (mode == 2'b00) begin stopped = 1'b1; break; end
    end
    if (!stopped || pc !== 32'h0000_000C || bp_hit !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stop: stopped=%b pc=%h hit=%b want 1,0000000c,1", stopped, pc, bp_hit);
    end
    vectors++;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b0, 1'b0, 1'b0);
      if (cpu_ce) ce_seen++;
    end
    if (ce_seen != 1 || bp_hit !== 1'b0 || pc !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL bp_step_off: pulses=%0d hit=%b pc=%h want 1,0,00000010", ce_seen, bp_hit, pc);
    end
    vectors++;
    pc_follow = 1'b0; bp_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_run();
    test_halt();
    test_priority();
    test_reset_mid_burst();
    test_random();
`ifdef DEBUG_STEP_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
